// File: rtl/fnd_scan_controller_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int unsigned FND_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_SHOW
  } fnd_state_e;

  function automatic logic [BCD_W-1:0] digit_nibble(
    input logic [FND_DIGITS*BCD_W-1:0] bcd,
    input logic [1:0]                  idx
  );
    return bcd[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Display-data and digit-drive signals between host, scan controller and FND decoder.
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic                          i_en;
  logic [FND_DIGITS*BCD_W-1:0]   i_bcd;
  logic [FND_DIGITS-1:0]         i_dp;
  logic                          i_blankLeadingZero;

  logic [1:0]                    o_digitSelect;
  logic                          o_en;
  logic [BCD_W-1:0]              o_bcd;
  logic                          o_dp;
  logic                          o_scanTick;

  // Scan controller side: consumes display data, drives the decoder.
  modport master (
    input  i_en, i_bcd, i_dp, i_blankLeadingZero,
    output o_digitSelect, o_en, o_bcd, o_dp, o_scanTick
  );

  // Host / decoder side.
  modport slave (
    output i_en, i_bcd, i_dp, i_blankLeadingZero,
    input  o_digitSelect, o_en, o_bcd, o_dp, o_scanTick
  );

endinterface

// File: rtl/fnd_scan_controller_lz_mask.sv
// Leading-zero suppress mask: bit k set when digits 3..k are all zero (digit 0 never).
module fnd_lz_mask
  import fnd_pkg::*;
(
  input  logic [FND_DIGITS*BCD_W-1:0] bcd,
  output logic [FND_DIGITS-1:0]       mask
);

  logic zero_run;

  always_comb begin
    mask     = '0;
    zero_run = 1'b1;
    for (int unsigned k = FND_DIGITS-1; k >= 1; k--) begin
      zero_run = zero_run && (bcd[k*BCD_W +: BCD_W] == '0);
      mask[k]  = zero_run;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scan driver with blank gap, leading-zero
// suppression and once-per-frame snapshot of the display value.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fnd_scan_controller_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - BLANK_CYCLES - 1);

  fnd_state_e                  state_q, state_n;
  logic [CNT_W-1:0]            cnt_q, cnt_n;
  logic [1:0]                  digit_q, digit_n;
  logic [FND_DIGITS*BCD_W-1:0] shadow_bcd_q, shadow_bcd_n;
  logic [FND_DIGITS-1:0]       shadow_dp_q, shadow_dp_n;
  logic [FND_DIGITS-1:0]       lz_mask_n;

  fnd_lz_mask u_lz_mask (
    .bcd  (shadow_bcd_n),
    .mask (lz_mask_n)
  );

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    digit_n      = digit_q;
    shadow_bcd_n = shadow_bcd_q;
    shadow_dp_n  = shadow_dp_q;
    if (!bus.i_en) begin
      state_n = S_OFF;
      cnt_n   = '0;
      digit_n = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_n = S_BLANK;
          cnt_n   = '0;
          digit_n = '0;
        end
        S_BLANK: begin
          // Snapshot once per frame, at the end of digit 0's first blank cycle.
          if (digit_q == '0 && cnt_q == '0) begin
            shadow_bcd_n = bus.i_bcd;
            shadow_dp_n  = bus.i_dp;
          end
          if (cnt_q == BLANK_LAST) begin
            state_n = S_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            digit_n = digit_q + 1'b1;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
          digit_n = '0;
        end
      endcase
    end
  end

  // Outputs are loaded from next-state values so each output cycle matches
  // the state/counter held in that same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q           <= S_BLANK;
      cnt_q             <= '0;
      digit_q           <= '0;
      shadow_bcd_q      <= '0;
      shadow_dp_q       <= '0;
      bus.o_digitSelect <= '0;
      bus.o_en          <= 1'b0;
      bus.o_bcd         <= '0;
      bus.o_dp          <= 1'b0;
      bus.o_scanTick    <= 1'b0;
    end else begin
      state_q           <= state_n;
      cnt_q             <= cnt_n;
      digit_q           <= digit_n;
      shadow_bcd_q      <= shadow_bcd_n;
      shadow_dp_q       <= shadow_dp_n;
      bus.o_digitSelect <= digit_n;
      bus.o_en          <= (state_n == S_SHOW) &&
                           !(bus.i_blankLeadingZero && lz_mask_n[digit_n]);
      bus.o_bcd         <= (state_n == S_OFF) ? '0 : digit_nibble(shadow_bcd_n, digit_n);
      bus.o_dp          <= (state_n != S_OFF) && shadow_dp_n[digit_n];
      bus.o_scanTick    <= (state_n == S_SHOW) && (digit_n == 2'd3) && (cnt_n == SHOW_LAST);
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with TICK_DIV=8, BLANK_CYCLES=2.
module tb_fnd_scan_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad   = 0;

  fnd_scan_controller_if bus ();

  fnd_scan_controller #(
    .TICK_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: the first cycle after reset is released.
  task automatic do_reset(input logic [15:0] bcd, input logic [3:0] dp, input logic blank);
    bus.i_en               = 1'b1;
    bus.i_bcd              = bcd;
    bus.i_dp               = dp;
    bus.i_blankLeadingZero = blank;
    rst = 1'b1;
    step;
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] sel, input logic en,
                           input logic [3:0] bcd, input logic dp, input logic tick);
    check({tag, ".sel"},  32'(bus.o_digitSelect), 32'(sel));
    check({tag, ".en"},   32'(bus.o_en),          32'(en));
    check({tag, ".bcd"},  32'(bus.o_bcd),         32'(bcd));
    check({tag, ".dp"},   32'(bus.o_dp),          32'(dp));
    check({tag, ".tick"}, 32'(bus.o_scanTick),    32'(tick));
  endtask

  // Slot = 8 cycles (2 blank + 6 show), frame = 32 cycles. f1/f2 are the
  // expected snapshots and lit-digit masks for frame 0 and frame 1.
  task automatic run_frames(input string tag, input int unsigned ncyc,
                            input int unsigned chg_at, input logic [15:0] chg_bcd,
                            input logic [15:0] f1_bcd, input logic [15:0] f2_bcd,
                            input logic [3:0] f1_on, input logic [3:0] f2_on,
                            input logic [3:0] dp_mask);
    int unsigned slot, pos;
    logic [15:0] word;
    logic [3:0]  on;
    string t;
    for (int unsigned c = 0; c < ncyc; c++) begin
      slot = (c / 8) % 4;
      pos  = c % 8;
      word = (c < 32) ? f1_bcd : f2_bcd;
      on   = (c < 32) ? f1_on  : f2_on;
      t    = $sformatf("%s.c%0d", tag, c);
      check({t, ".sel"}, 32'(bus.o_digitSelect), slot);
      if (pos < 2) begin
        check({t, ".en"}, 32'(bus.o_en), 32'd0);
      end else begin
        check({t, ".en"},  32'(bus.o_en),  32'(on[slot]));
        check({t, ".bcd"}, 32'(bus.o_bcd), 32'(word[slot*4 +: 4]));
        check({t, ".dp"},  32'(bus.o_dp),  32'(dp_mask[slot]));
      end
      check({t, ".tick"}, 32'(bus.o_scanTick), 32'((slot == 3 && pos == 7) ? 1 : 0));
      if (c == chg_at) bus.i_bcd = chg_bcd;
      step;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.i_en = 1'b0;
    bus.i_bcd = '0;
    bus.i_dp = '0;
    bus.i_blankLeadingZero = 1'b0;
    #1;

    // Normal scan; input change at cycle 12 only appears in frame 2.
    do_reset(16'h1234, 4'b0100, 1'b0);
    check_all("rst", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    run_frames("scan", 40, 12, 16'h5678, 16'h1234, 16'h5678, 4'hF, 4'hF, 4'b0100);

    // Leading-zero suppression, then all-zero value in the next frame.
    do_reset(16'h0050, 4'b0000, 1'b1);
    run_frames("lz", 64, 20, 16'h0000, 16'h0050, 16'h0000, 4'b0011, 4'b0001, 4'b0000);

    // Non-BCD nibble passes through, no suppression.
    do_reset(16'h000A, 4'b0000, 1'b0);
    run_frames("hex", 32, 999, 16'h0000, 16'h000A, 16'h000A, 4'hF, 4'hF, 4'b0000);

    // Disable at cycle 20, re-enable at cycle 30 with a new value.
    do_reset(16'h1234, 4'b0100, 1'b0);
    for (int unsigned c = 0; c < 20; c++) step;
    check_all("pre_off", 2'd2, 1'b1, 4'h2, 1'b1, 1'b0);
    bus.i_en = 1'b0;
    step;
    for (int unsigned c = 21; c < 30; c++) begin
      check_all($sformatf("off.c%0d", c), 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
      step;
    end
    bus.i_en  = 1'b1;
    bus.i_bcd = 16'h9876;
    check_all("off.c30", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    step;
    check({"on.c31", ".en"},  32'(bus.o_en), 32'd0);
    check({"on.c31", ".sel"}, 32'(bus.o_digitSelect), 32'd0);
    step;
    check({"on.c32", ".en"},  32'(bus.o_en), 32'd0);
    step;
    check_all("on.c33", 2'd0, 1'b1, 4'h6, 1'b0, 1'b0);
    for (int unsigned c = 33; c < 41; c++) step;
    check_all("on.c41", 2'd1, 1'b1, 4'h7, 1'b0, 1'b0);

    // Reset mid-scan while digit 2 is showing.
    do_reset(16'h1234, 4'b0100, 1'b0);
    for (int unsigned c = 0; c < 19; c++) step;
    check_all("mid.c19", 2'd2, 1'b1, 4'h2, 1'b1, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check_all("mid.c20", 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    step;
    check({"mid.c21", ".en"}, 32'(bus.o_en), 32'd0);
    step;
    check_all("mid.c22", 2'd0, 1'b1, 4'h4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
